i2c_axis_target: RTL and testbench

I2C_AXIS_TARGET -- requirements
Module: i2c_axis_target

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_axis_target_if.sv | 11 +
 rtl/i2c_bus_sampler.sv | 80 ++++++++
 rtl/i2c_axis_target.sv | 192 +++++++++++++++++++
 tb/tb_i2c_axis_target.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-only target that feeds an AXI-Stream port.
// Holds the FSM state enum, ACK/NACK bus levels and the width helpers.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_axis_target_if.sv
// AXI-Stream word channel between the I2C target and its downstream consumer.
interface i2c_axis_target_if #(
    parameter int WIDTH = 16
);
    logic             tvalid;
    logic             tready;
    logic [WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/i2c_bus_sampler.sv
// Brings SCL/SDA into the clk domain and detects SCL edges plus START/STOP.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchronizers.
module i2c_bus_sampler
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arstn,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   w_scl;
    logic                   w_sda;
    logic                   r_scl_d;
    logic                   r_sda_d;

    // Reset to 1 so an idle bus is seen at release and no false edge fires.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] r_scl_hist;
    logic [1:0] r_sda_hist;
    logic       r_scl_flt;
    logic       r_sda_flt;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_scl_hist <= '1;
            r_sda_hist <= '1;
            r_scl_flt  <= 1'b1;
            r_sda_flt  <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_sync[SYNC_STAGES-1]};
            r_sda_hist <= {r_sda_hist[0], r_sda_sync[SYNC_STAGES-1]};
            r_scl_flt  <= majority3(r_scl_sync[SYNC_STAGES-1], r_scl_hist[1], r_scl_hist[0]);
            r_sda_flt  <= majority3(r_sda_sync[SYNC_STAGES-1], r_sda_hist[1], r_sda_hist[0]);
        end
    end

    assign w_scl = r_scl_flt;
    assign w_sda = r_sda_flt;
`else
    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_axis_target.sv
// Write-only I2C target: assembles received bytes into AXI-Stream words, MSB byte first.
// A full word is NACKed and dropped while the previous word is still waiting for tready.
module i2c_axis_target
    import i2c_pkg::*;
#(
    parameter int         AXIS_DATA_WIDTH = 16,
    parameter logic [6:0] DEV_ADDR        = 7'h50,
    parameter int         SYNC_STAGES     = 2
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic                i2c_scl,
    input  logic                i2c_sda,
    output logic                i2c_sda_oe,
    i2c_axis_target_if.master   m_axis,
    output logic                busy,
    output logic                drop
);

    localparam int               BYTES     = bytes_of(AXIS_DATA_WIDTH);
    localparam int               CNT_W     = cnt_width(BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    state_e               r_state, w_state_nx;
    logic [2:0]           r_bit_cnt, w_bit_cnt_nx;
    logic [CNT_W-1:0]     r_byte_cnt, w_byte_cnt_nx;
    logic                 r_ack_drv, w_ack_drv_nx;
    logic                 r_ack_bit, w_ack_bit_nx;
    logic                 r_oe, w_oe_nx;
    logic                 r_drop, w_drop;
    logic                 w_wr_byte;
    logic                 w_wr_word;
    logic [6:0]           r_shift;
    logic [7:0]           w_byte;
    logic                 r_tvalid;
    logic [AXIS_DATA_WIDTH-1:0] r_tdata;
    logic [AXIS_DATA_WIDTH-1:0] w_word_full;

    i2c_bus_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk        (clk),
        .arstn      (arstn),
        .i_scl      (i2c_scl),
        .i_sda      (i2c_sda),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_byte = {r_shift, w_sda};

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        w_state_nx    = r_state;
        w_bit_cnt_nx  = r_bit_cnt;
        w_byte_cnt_nx = r_byte_cnt;
        w_ack_drv_nx  = r_ack_drv;
        w_ack_bit_nx  = r_ack_bit;
        w_oe_nx       = r_oe;
        w_drop        = 1'b0;
        w_wr_byte     = 1'b0;
        w_wr_word     = 1'b0;

        if (w_stop || w_start) begin
            // Any bus boundary aborts the transfer and discards a partial word.
            w_state_nx    = w_stop ? ST_IDLE : ST_ADDR;
            w_bit_cnt_nx  = '0;
            w_byte_cnt_nx = '0;
            w_ack_drv_nx  = 1'b0;
            w_oe_nx       = 1'b0;
            w_drop        = (r_byte_cnt != '0);
        end else begin
            unique case (r_state)
                ST_IDLE, ST_IGNORE: ;
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_byte[7:1] == DEV_ADDR && w_byte[0] == 1'b0) begin
                                w_state_nx   = ST_ADDR_ACK;
                                w_ack_bit_nx = ACK;
                            end else begin
                                w_state_nx   = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nx = ST_DATA_ACK;
                            if (r_byte_cnt == LAST_BYTE) begin
                                w_byte_cnt_nx = '0;
                                if (r_tvalid) begin
                                    w_ack_bit_nx = NACK;
                                    w_drop       = 1'b1;
                                end else begin
                                    w_ack_bit_nx = ACK;
                                    w_wr_word    = 1'b1;
                                end
                            end else begin
                                w_ack_bit_nx  = ACK;
                                w_wr_byte     = 1'b1;
                                w_byte_cnt_nx = r_byte_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    // First fall opens the ACK bit, the second one closes it.
                    if (w_scl_fall) begin
                        if (!r_ack_drv) begin
                            w_ack_drv_nx = 1'b1;
                            w_oe_nx      = (r_ack_bit == ACK);
                        end else begin
                            w_ack_drv_nx = 1'b0;
                            w_oe_nx      = 1'b0;
                            w_state_nx   = ST_DATA;
                        end
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_ack_drv  <= 1'b0;
            r_ack_bit  <= NACK;
            r_oe       <= 1'b0;
            r_drop     <= 1'b0;
            r_shift    <= '0;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
        end else begin
            r_bit_cnt  <= w_bit_cnt_nx;
            r_byte_cnt <= w_byte_cnt_nx;
            r_ack_drv  <= w_ack_drv_nx;
            r_ack_bit  <= w_ack_bit_nx;
            r_oe       <= w_oe_nx;
            r_drop     <= w_drop;
            if (w_scl_rise) r_shift <= w_byte[6:0];
            if (w_wr_word) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_word_full;
            end else if (r_tvalid && m_axis.tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    generate
        if (BYTES > 1) begin : g_part
            logic [AXIS_DATA_WIDTH-9:0] r_part;

            always_ff @(posedge clk or negedge arstn) begin
                if (!arstn)         r_part <= '0;
                else if (w_wr_byte) r_part[8*(BYTES-2-int'(r_byte_cnt)) +: 8] <= w_byte;
            end

            assign w_word_full = {r_part, w_byte};
        end else begin : g_single
            assign w_word_full = w_byte;
        end
    endgenerate

    assign i2c_sda_oe    = r_oe;
    assign busy          = (r_state != ST_IDLE);
    assign drop          = r_drop;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_tdata;

endmodule

// File: tb/tb_i2c_axis_target.sv
// Self-checking bench for i2c_axis_target: a bit-banged I2C master against a byte-level model.
module tb_i2c_axis_target;
    import i2c_pkg::*;

    localparam int W     = 16;
    localparam int BYTES = W / 8;
    localparam int Q     = 10;

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic i2c_sda;
    logic i2c_sda_oe;
    logic busy;
    logic drop;

    i2c_axis_target_if #(.WIDTH(W)) axis ();

    assign i2c_sda = sda_m & ~i2c_sda_oe;

    i2c_axis_target #(
        .AXIS_DATA_WIDTH (W),
        .DEV_ADDR        (7'h50),
        .SYNC_STAGES     (2)
    ) dut (
        .clk        (clk),
        .arstn      (arstn),
        .i2c_scl    (scl_m),
        .i2c_sda    (i2c_sda),
        .i2c_sda_oe (i2c_sda_oe),
        .m_axis     (axis),
        .busy       (busy),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    int             drop_cnt = 0;
    int             oe_cnt   = 0;
    int             stab_err = 0;
    logic [W-1:0]   got_q[$];
    logic           prev_hold = 1'b0;
    logic [W-1:0]   prev_data = '0;

    always @(negedge clk) begin
        if (arstn) begin
            if (drop)       drop_cnt <= drop_cnt + 1;
            if (i2c_sda_oe) oe_cnt   <= oe_cnt + 1;
            if (axis.tvalid && axis.tready) got_q.push_back(axis.tdata);
            if (prev_hold && axis.tdata !== prev_data) stab_err <= stab_err + 1;
            prev_hold <= axis.tvalid && !axis.tready;
            prev_data <= axis.tdata;
        end else begin
            prev_hold <= 1'b0;
        end
    end

    // Byte-level reference model
    logic [7:0]   part_q[$];
    logic [W-1:0] exp_q[$];
    bit           pend_v   = 1'b0;
    logic [W-1:0] pend_w   = '0;
    int           exp_drop = 0;
    bit           rdy      = 1'b0;
    logic [7:0]   data_q[$];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want)
        else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic model_boundary();
        if (part_q.size() > 0) exp_drop++;
        part_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, output logic ack);
        logic [W-1:0] w;
        if (part_q.size() == BYTES - 1) begin
            if (pend_v) begin
                exp_drop++;
                part_q.delete();
                ack = NACK;
            end else begin
                w = '0;
                foreach (part_q[i]) w = (w << 8) | W'(part_q[i]);
                w = (w << 8) | W'(b);
                part_q.delete();
                if (rdy) exp_q.push_back(w);
                else begin
                    pend_v = 1'b1;
                    pend_w = w;
                end
                ack = ACK;
            end
        end else begin
            part_q.push_back(b);
            ack = ACK;
        end
    endtask

    task automatic set_ready(input bit v);
        axis.tready = v;
        rdy = v;
        tick(4);
        if (v && pend_v) begin
            exp_q.push_back(pend_w);
            pend_v = 1'b0;
        end
    endtask

    task automatic start_c();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int glitch_bit);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i];
            tick(Q);
            scl_m = 1'b1;
            if (i == glitch_bit) begin
                tick(Q / 2);
                scl_m = 1'b0;
                tick(1);
                scl_m = 1'b1;
                tick(2 * Q - Q / 2 - 1);
            end else begin
                tick(2 * Q);
            end
            scl_m = 1'b0;
            tick(Q);
        end
    endtask

    task automatic ack_slot(output logic ack);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        ack = i2c_sda;
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic txn(input logic [7:0] addr, input bit end_stop, input int glitch);
        logic ack;
        logic want;
        bit   addr_ok;
        int   oe0;
        model_boundary();
        start_c();
        oe0     = oe_cnt;
        addr_ok = (addr[7:1] == 7'h50) && !addr[0];
        send_bits(addr, -1);
        ack_slot(ack);
        chk("addr_ack", 32'(ack), 32'(addr_ok ? ACK : NACK));
        foreach (data_q[i]) begin
            if (addr_ok) model_byte(data_q[i], want);
            else         want = NACK;
            send_bits(data_q[i], (i == 0) ? glitch : -1);
            ack_slot(ack);
            if (glitch < 0) chk("data_ack", 32'(ack), 32'(want));
        end
        if (glitch < 0) chk("busy_mid", 32'(busy), 32'd1);
        if (!addr_ok)   chk("oe_quiet", 32'(oe_cnt - oe0), 32'd0);
        if (end_stop) begin
            stop_c();
            model_boundary();
            tick(2 * Q);
            if (glitch < 0) chk("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    task automatic check_outputs(input string tag);
        tick(4);
        chk({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
        chk({tag, "_tvalid"}, 32'(axis.tvalid), 32'(pend_v));
        if (pend_v) chk({tag, "_tdata_held"}, 32'(axis.tdata), 32'(pend_w));
        chk({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic want;
        logic found;
        int   n;
        axis.tready = 1'b0;
        tick(3);
        chk("rst_oe",     32'(i2c_sda_oe),  32'd0);
        chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
        chk("rst_tdata",  32'(axis.tdata),  32'd0);
        chk("rst_busy",   32'(busy),        32'd0);
        chk("rst_drop",   32'(drop),        32'd0);
        arstn = 1'b1;
        tick(5);

        // Basic write of one word
        set_ready(1'b1);
        data_q = '{8'h12, 8'h34};
        txn(8'hA0, 1'b1, -1);
        check_outputs("write");

        // Wrong address and read request are ignored
        data_q = '{8'h5A};
        txn(8'hA2, 1'b1, -1);
        check_outputs("bad_addr");
        data_q = '{8'h5A};
        txn(8'hA1, 1'b1, -1);
        check_outputs("read_req");

        // Back-pressure: second word NACKed while the first one waits
        set_ready(1'b0);
        data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        txn(8'hA0, 1'b1, -1);
        check_outputs("backpressure");
        set_ready(1'b1);
        check_outputs("release");

        // Partial words discarded by STOP and by repeated START
        data_q = '{8'h55};
        txn(8'hA0, 1'b1, -1);
        check_outputs("partial_stop");
        data_q = '{8'h66};
        txn(8'hA0, 1'b0, -1);
        check_outputs("partial_rs_a");
        data_q = '{8'h77, 8'h88};
        txn(8'hA0, 1'b1, -1);
        check_outputs("partial_rs_b");

        // Randomized transactions
        for (int k = 0; k < 6; k++) begin
            set_ready(1'($urandom_range(0, 1)));
            n = $urandom_range(1, 5);
            data_q.delete();
            for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
            txn(($urandom_range(0, 3) == 0) ? 8'hA2 : 8'hA0, 1'b1, -1);
            check_outputs("random");
        end
        set_ready(1'b1);
        check_outputs("random_flush");

        // Reset while the target drives an ACK with a word pending
        set_ready(1'b0);
        data_q = '{8'h11, 8'h22};
        txn(8'hA0, 1'b0, -1);
        model_byte(8'h33, want);
        send_bits(8'h33, -1);
        sda_m = 1'b1;
        tick(Q);
        chk("oe_before_reset", 32'(i2c_sda_oe), 32'(want == ACK));
        arstn = 1'b0;
        #1;
        chk("oe_in_reset",     32'(i2c_sda_oe),  32'd0);
        chk("tvalid_in_reset", 32'(axis.tvalid), 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(5);
        arstn = 1'b1;
        part_q.delete();
        pend_v = 1'b0;
        tick(5);
        chk("busy_after_reset",  32'(busy),       32'd0);
        chk("tdata_after_reset", 32'(axis.tdata), 32'd0);
        set_ready(1'b1);
        check_outputs("after_reset");
        data_q = '{8'hAB, 8'hCD};
        txn(8'hA0, 1'b1, -1);
        check_outputs("post_reset_write");

        chk("tdata_stable", 32'(stab_err), 32'd0);

        // One-clock SCL glitch inside the first data byte
        data_q = '{8'h12, 8'h34};
        txn(8'hA0, 1'b1, 4);
        tick(40);
        found = 1'b0;
        foreach (got_q[i]) if (got_q[i] == 16'h1234) found = 1'b1;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        chk("glitch_word", 32'(found), 32'd1);
`else
        chk("glitch_word", 32'(found), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
